// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption register-file arbiter.
// Contents: arbiter FSM state type, register address map of the
// decryption block, default bus widths and grantee encoding.
package decryption_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
  localparam int unsigned DEFAULT_REG_WIDTH  = 16;

  localparam logic [7:0] REG_SELECT  = 8'h00;
  localparam logic [7:0] REG_CAESAR  = 8'h10;
  localparam logic [7:0] REG_SCYTALE = 8'h12;
  localparam logic [7:0] REG_ZIGZAG  = 8'h14;

  // Grantee / owner encoding
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/decryption_rr_pick.sv
// Two-way round-robin selector.
// Ports:
//   a_req, b_req : pending requests
//   ptr          : last grantee (0 = A, 1 = B)
//   grant        : selected requester (0 = A, 1 = B), meaningful when valid
//   valid        : at least one request pending
module decryption_rr_pick
  import decryption_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic ptr,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = a_req | b_req;
    grant = GRANT_A;
    if (a_req && b_req) begin
      // Tie: the side not served last wins
      grant = ~ptr;
    end else if (b_req) begin
      grant = GRANT_B;
    end
  end

endmodule

// File: rtl/decryption_regfile_arbiter.sv
// Arbitrates two requesters (A, B) onto one shared register-file bus.
// One transaction at a time: IDLE -> ISSUE (one-cycle rf strobe) -> WAIT
// (until rf_done) -> RESP (one-cycle done pulse to the grantee) -> IDLE.
// All outputs are registered.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     : requester A command (level request)
//   a_rdata/a_done/a_error        : requester A response
//   b_*                           : requester B, same as A
//   rf_addr/rf_wdata/rf_read/rf_write : shared register-file command
//   rf_rdata/rf_done/rf_error     : register-file response
//   busy                          : high outside IDLE
//   owner                         : current or last grantee (0 = A, 1 = B)
// Optional feature: define ARB_TIMEOUT_EN to force an error response after
// timeout_cycles WAIT cycles without rf_done.
module decryption_regfile_arbiter
  import decryption_pkg::*;
#(
  parameter int unsigned addr_width     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned reg_width      = DEFAULT_REG_WIDTH,
  parameter int unsigned timeout_cycles = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [addr_width-1:0] a_addr,
  input  logic [reg_width-1:0]  a_wdata,
  output logic [reg_width-1:0]  a_rdata,
  output logic                  a_done,
  output logic                  a_error,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [addr_width-1:0] b_addr,
  input  logic [reg_width-1:0]  b_wdata,
  output logic [reg_width-1:0]  b_rdata,
  output logic                  b_done,
  output logic                  b_error,
  output logic [addr_width-1:0] rf_addr,
  output logic [reg_width-1:0]  rf_wdata,
  output logic                  rf_read,
  output logic                  rf_write,
  input  logic [reg_width-1:0]  rf_rdata,
  input  logic                  rf_done,
  input  logic                  rf_error,
  output logic                  busy,
  output logic                  owner
);

  if (timeout_cycles == 0) begin : g_bad_timeout
    $error("timeout_cycles must be at least 1");
  end

  arb_state_t state, state_nx;

  logic                  ptr, ptr_nx;
  logic                  cur_we, cur_we_nx;
  logic                  owner_nx;
  logic [addr_width-1:0] addr_nx;
  logic [reg_width-1:0]  wdata_nx;
  logic                  read_nx, write_nx, busy_nx;
  logic                  a_done_nx, b_done_nx, a_error_nx, b_error_nx;
  logic [reg_width-1:0]  a_rdata_nx, b_rdata_nx;
  logic                  fin, fin_error;
  logic [reg_width-1:0]  fin_rdata;
  logic                  pick_grant, pick_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned cnt_w = $clog2(timeout_cycles + 1);
  logic [cnt_w-1:0] cnt, cnt_nx;
`endif

  decryption_rr_pick u_pick (
    .a_req (a_req),
    .b_req (b_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Next-state and next-output logic; the register stage below makes every
  // output take effect in the same cycle as the state it belongs to.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    cur_we_nx = cur_we;
    owner_nx  = owner;
    addr_nx   = rf_addr;
    wdata_nx  = rf_wdata;
    read_nx   = 1'b0;
    write_nx  = 1'b0;
    fin       = 1'b0;
    fin_error = 1'b0;
    fin_rdata = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_nx    = cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (pick_valid) begin
          state_nx = S_ISSUE;
          owner_nx = pick_grant;
          if (pick_grant == GRANT_B) begin
            cur_we_nx = b_we;
            addr_nx   = b_addr;
            wdata_nx  = b_wdata;
          end else begin
            cur_we_nx = a_we;
            addr_nx   = a_addr;
            wdata_nx  = a_wdata;
          end
          read_nx  = ~cur_we_nx;
          write_nx = cur_we_nx;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_nx   = '0;
`endif
      end
      S_WAIT: begin
        if (rf_done) begin
          state_nx  = S_RESP;
          fin       = 1'b1;
          fin_rdata = cur_we ? '0 : rf_rdata;
          fin_error = rf_error;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == cnt_w'(timeout_cycles - 1)) begin
          state_nx  = S_RESP;
          fin       = 1'b1;
          fin_error = 1'b1;
        end else begin
          cnt_nx = cnt + cnt_w'(1);
        end
`endif
      end
      S_RESP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (fin) begin
      ptr_nx = owner;
    end
    a_done_nx  = fin & (owner == GRANT_A);
    b_done_nx  = fin & (owner == GRANT_B);
    a_error_nx = a_done_nx & fin_error;
    b_error_nx = b_done_nx & fin_error;
    a_rdata_nx = a_done_nx ? fin_rdata : '0;
    b_rdata_nx = b_done_nx ? fin_rdata : '0;
    busy_nx    = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= GRANT_B;
      owner    <= GRANT_B;
      cur_we   <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      rf_read  <= 1'b0;
      rf_write <= 1'b0;
      busy     <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      a_error  <= 1'b0;
      b_error  <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      cur_we   <= cur_we_nx;
      rf_addr  <= addr_nx;
      rf_wdata <= wdata_nx;
      rf_read  <= read_nx;
      rf_write <= write_nx;
      busy     <= busy_nx;
      a_done   <= a_done_nx;
      b_done   <= b_done_nx;
      a_error  <= a_error_nx;
      b_error  <= b_error_nx;
      a_rdata  <= a_rdata_nx;
      b_rdata  <= b_rdata_nx;
`ifdef ARB_TIMEOUT_EN
      cnt      <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_decryption_regfile_arbiter.sv
// Scoreboard bench for decryption_regfile_arbiter: a transaction-level model
// (register map array + round-robin service order) pushes expected responses
// and expected register-file commands; monitors pop and compare them.
`timescale 1ns/1ps
module tb_decryption_regfile_arbiter;
  import decryption_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned RW = 16;
  localparam int unsigned TO = 15;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [RW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          who;
    logic [RW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [RW-1:0] a_wdata = '0, b_wdata = '0;
  logic [RW-1:0] a_rdata, b_rdata;
  logic          a_done, b_done, a_error, b_error;
  logic [AW-1:0] rf_addr;
  logic [RW-1:0] rf_wdata;
  logic          rf_read, rf_write;
  logic [RW-1:0] rf_rdata = '0;
  logic          rf_done = 1'b0, rf_error = 1'b0;
  logic          busy, owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decryption_regfile_arbiter #(
    .addr_width     (AW),
    .reg_width      (RW),
    .timeout_cycles (TO)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done), .a_error(a_error),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done), .b_error(b_error),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_read(rf_read), .rf_write(rf_write),
    .rf_rdata(rf_rdata), .rf_done(rf_done), .rf_error(rf_error),
    .busy(busy), .owner(owner)
  );

  function automatic logic mapped(input logic [AW-1:0] a);
    return (a == REG_SELECT) || (a == REG_CAESAR) || (a == REG_SCYTALE) || (a == REG_ZIGZAG);
  endfunction

  task automatic chk(input logic ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // ---------------- register-file responder ----------------
  logic [RW-1:0] slave_mem [256] = '{18: 16'hFFFF, 20: 16'h0002, default: 16'h0000};
  logic rf_mute = 1'b0;
  int   rf_delay = 0;
  logic pend = 1'b0;
  int   pend_cnt = 0;
  cmd_t pend_cmd = '0;
  logic go;
  cmd_t gc;

  always_comb begin
    go = 1'b0;
    gc = '0;
    if ((rf_read || rf_write) && !rf_mute) begin
      if (rf_delay == 0) begin
        go = 1'b1;
        gc = {rf_write, rf_addr, rf_wdata};
      end
    end else if (pend && pend_cnt == 0) begin
      go = 1'b1;
      gc = pend_cmd;
    end
  end

  // Deliberately blind to rst: a response still in flight at reset arrives late.
  always @(posedge clk) begin
    rf_done  <= go;
    rf_error <= go && !mapped(gc.addr);
    rf_rdata <= (go && mapped(gc.addr) && !gc.we) ? slave_mem[gc.addr] : '0;
    if (go && mapped(gc.addr) && gc.we) slave_mem[gc.addr] <= gc.wdata;
    if ((rf_read || rf_write) && !rf_mute) begin
      if (rf_delay != 0) begin
        pend     <= 1'b1;
        pend_cnt <= rf_delay - 1;
        pend_cmd <= {rf_write, rf_addr, rf_wdata};
      end
    end else if (pend) begin
      if (pend_cnt == 0) pend <= 1'b0;
      else pend_cnt <= pend_cnt - 1;
    end
  end

  // ---------------- reference model ----------------
  logic [RW-1:0] model_mem [256];
  logic          m_last;
  exp_t          exp_q[$];
  cmd_t          rf_q[$];
  cmd_t          cur_a[$];
  cmd_t          cur_b[$];

  task automatic model_apply(input logic who, input cmd_t c);
    exp_t e;
    rf_q.push_back(c);
    e.who   = who;
    e.err   = !mapped(c.addr);
    e.rdata = '0;
    if (!e.err) begin
      if (c.we) model_mem[c.addr] = c.wdata;
      else e.rdata = model_mem[c.addr];
    end
    exp_q.push_back(e);
    m_last = who;
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] addr, input logic [RW-1:0] wd);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wd;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int k;
    c.we    = 1'($urandom_range(0, 1));
    c.wdata = RW'($urandom);
    k = int'($urandom_range(0, 4));
    case (k)
      0: c.addr = REG_SELECT;
      1: c.addr = REG_CAESAR;
      2: c.addr = REG_SCYTALE;
      3: c.addr = REG_ZIGZAG;
      default: begin
        c.addr = AW'($urandom_range(0, 255));
        while (mapped(c.addr)) c.addr = AW'($urandom_range(0, 255));
      end
    endcase
    return c;
  endfunction

  // ---------------- monitors ----------------
  logic          prev_strobe = 1'b0;
  logic [AW-1:0] held_addr = '0;
  logic [RW-1:0] held_wdata = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    cmd_t r;
    logic strobe;
    if (a_done && b_done)
      chk(1'b0, "dual_done", "got a_done=1 b_done=1, required at most one");
    if (a_done || b_done) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_done", $sformatf("got a_done=%0d b_done=%0d, required none", a_done, b_done));
      end else begin
        e = exp_q.pop_front();
        chk(b_done == e.who && (b_done ? b_rdata : a_rdata) == e.rdata && (b_done ? b_error : a_error) == e.err,
            "resp", $sformatf("got who=%0d rdata=%h err=%0d, required who=%0d rdata=%h err=%0d",
                              b_done, b_done ? b_rdata : a_rdata, b_done ? b_error : a_error,
                              e.who, e.rdata, e.err));
      end
    end
    if (!a_done) chk(a_rdata == '0 && !a_error, "a_quiet", $sformatf("got a_rdata=%h a_error=%0d, required 0", a_rdata, a_error));
    if (!b_done) chk(b_rdata == '0 && !b_error, "b_quiet", $sformatf("got b_rdata=%h b_error=%0d, required 0", b_rdata, b_error));
    strobe = rf_read || rf_write;
    if (strobe) begin
      chk(!(rf_read && rf_write), "strobe_onehot", "got rf_read=1 rf_write=1, required one");
      chk(!prev_strobe, "strobe_len", "got strobe high two cycles, required one");
      if (rf_q.size() == 0) begin
        chk(1'b0, "unexpected_strobe", $sformatf("got strobe addr=%h, required none", rf_addr));
      end else begin
        r = rf_q.pop_front();
        chk(rf_write == r.we && rf_addr == r.addr && (!r.we || rf_wdata == r.wdata), "rf_cmd",
            $sformatf("got we=%0d addr=%h wdata=%h, required we=%0d addr=%h wdata=%h",
                      rf_write, rf_addr, rf_wdata, r.we, r.addr, r.wdata));
      end
      held_addr  <= rf_addr;
      held_wdata <= rf_wdata;
    end else if (busy) begin
      chk(rf_addr == held_addr && rf_wdata == held_wdata, "rf_hold",
          $sformatf("got addr=%h wdata=%h, required addr=%h wdata=%h", rf_addr, rf_wdata, held_addr, held_wdata));
    end
    prev_strobe <= strobe;
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string name);
    chk(a_rdata == '0 && b_rdata == '0 && !a_done && !b_done && !a_error && !b_error &&
        rf_addr == '0 && rf_wdata == '0 && !rf_read && !rf_write && !busy && owner == 1'b1, name,
        $sformatf("got done=%0d%0d rd=%h/%h rf=%0d%0d addr=%h wd=%h busy=%0d owner=%0d, required all 0 and owner=1",
                  a_done, b_done, a_rdata, b_rdata, rf_read, rf_write, rf_addr, rf_wdata, busy, owner));
  endtask

  task automatic drive_a(input cmd_t c);
    a_we = c.we; a_addr = c.addr; a_wdata = c.wdata;
  endtask

  task automatic drive_b(input cmd_t c);
    b_we = c.we; b_addr = c.addr; b_wdata = c.wdata;
  endtask

  // Serve cur_a and cur_b: each side keeps req high until its list is used up.
  task automatic play();
    int ia, ib, budget;
    ia = 0; ib = 0;
    while (ia < cur_a.size() || ib < cur_b.size()) begin
      if (ia < cur_a.size() && (ib >= cur_b.size() || m_last == GRANT_B)) begin
        model_apply(GRANT_A, cur_a[ia]); ia++;
      end else begin
        model_apply(GRANT_B, cur_b[ib]); ib++;
      end
    end
    ia = 0; ib = 0;
    @(negedge clk);
    if (cur_a.size() > 0) begin drive_a(cur_a[0]); a_req = 1'b1; end
    if (cur_b.size() > 0) begin drive_b(cur_b[0]); b_req = 1'b1; end
    budget = 20 * (cur_a.size() + cur_b.size()) + 10;
    while ((a_req || b_req) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (a_done && a_req) begin
        ia++;
        if (ia < cur_a.size()) drive_a(cur_a[ia]); else a_req = 1'b0;
      end
      if (b_done && b_req) begin
        ib++;
        if (ib < cur_b.size()) drive_b(cur_b[ib]); else b_req = 1'b0;
      end
    end
    if (budget == 0) begin
      chk(1'b0, "round_timeout", $sformatf("got %0d/%0d A and %0d/%0d B completions in budget", ia, cur_a.size(), ib, cur_b.size()));
      a_req = 1'b0; b_req = 1'b0;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      exp_q.delete(); rf_q.delete(); m_last = GRANT_B;
    end
  endtask

  initial begin
    int n, na, nb;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    model_mem[REG_SCYTALE] = 16'hFFFF;
    model_mem[REG_ZIGZAG]  = 16'h0002;
    m_last = GRANT_B;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // Tie right after reset: A first (0xFFFF) then B (0x0002)
    cur_a.delete(); cur_b.delete();
    cur_a.push_back(mk(1'b0, REG_SCYTALE, '0));
    cur_b.push_back(mk(1'b0, REG_ZIGZAG, '0));
    play();

    // Lone write with exact latency
    model_apply(GRANT_A, mk(1'b1, REG_CAESAR, 16'h0003));
    @(negedge clk);
    a_we = 1'b1; a_addr = REG_CAESAR; a_wdata = 16'h0003; a_req = 1'b1;
    @(negedge clk);
    chk(rf_write && !rf_read && rf_addr == REG_CAESAR && rf_wdata == 16'h0003 && busy, "lat_strobe",
        $sformatf("got wr=%0d rd=%0d addr=%h wd=%h busy=%0d, required wr=1 rd=0 addr=10 wd=0003 busy=1",
                  rf_write, rf_read, rf_addr, rf_wdata, busy));
    @(negedge clk);
    chk(!rf_write && !rf_read && !a_done, "strobe_one_cycle",
        $sformatf("got wr=%0d rd=%0d a_done=%0d, required all 0", rf_write, rf_read, a_done));
    @(negedge clk);
    chk(a_done && !a_error && !b_done, "lat_done",
        $sformatf("got a_done=%0d a_error=%0d b_done=%0d, required 1 0 0", a_done, a_error, b_done));
    a_req = 1'b0;

    // Unmapped read from B
    cur_a.delete(); cur_b.delete();
    cur_b.push_back(mk(1'b0, 8'h20, '0));
    play();

    // Both held for four transactions: A, B, A, B
    cur_a.delete(); cur_b.delete();
    cur_a.push_back(mk(1'b0, REG_CAESAR, '0));
    cur_a.push_back(mk(1'b1, REG_SELECT, 16'h0001));
    cur_b.push_back(mk(1'b0, REG_SCYTALE, '0));
    cur_b.push_back(mk(1'b1, REG_ZIGZAG, 16'h1234));
    play();

    // Randomized rounds with varying regfile latency
    repeat (30) begin
      rf_delay = int'($urandom_range(0, 2));
      na = int'($urandom_range(0, 3));
      nb = int'($urandom_range(0, 3));
      if (na == 0 && nb == 0) na = 1;
      cur_a.delete(); cur_b.delete();
      for (int i = 0; i < na; i++) cur_a.push_back(rand_cmd());
      for (int i = 0; i < nb; i++) cur_b.push_back(rand_cmd());
      play();
    end

    // Reset during WAIT, with the regfile response arriving after reset
    rf_delay = 3;
    rf_q.push_back(mk(1'b0, REG_SCYTALE, '0));
    @(negedge clk);
    a_we = 1'b0; a_addr = REG_SCYTALE; a_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rf_read && n < 10);
    chk(rf_read, "abort_strobe", $sformatf("got rf_read=%0d after %0d cycles, required 1", rf_read, n));
    a_req = 1'b0;
    @(negedge clk);
    chk(busy, "abort_in_wait", $sformatf("got busy=%0d, required 1", busy));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort_reset_state");
    m_last = GRANT_B;
    repeat (6) @(negedge clk);
    chk(!busy, "abort_late_done_ignored", $sformatf("got busy=%0d, required 0", busy));
    rf_delay = 0;
    cur_a.delete(); cur_b.delete();
    cur_a.push_back(mk(1'b0, REG_CAESAR, '0));
    cur_b.push_back(mk(1'b0, REG_SELECT, '0));
    play();

    // Regfile never answers
    rf_mute = 1'b1;
    rf_q.push_back(mk(1'b0, REG_CAESAR, '0));
`ifdef ARB_TIMEOUT_EN
    exp_q.push_back({GRANT_A, 16'h0000, 1'b1});
    m_last = GRANT_A;
`endif
    @(negedge clk);
    a_we = 1'b0; a_addr = REG_CAESAR; a_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rf_read && n < 10);
    chk(rf_read, "mute_strobe", $sformatf("got rf_read=%0d after %0d cycles, required 1", rf_read, n));
`ifdef ARB_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!a_done && n < 40);
    a_req = 1'b0;
    chk(a_done && a_error && n == 16, "timeout_latency",
        $sformatf("got a_done=%0d a_error=%0d %0d cycles after strobe, required 1 1 16", a_done, a_error, n));
`else
    a_req = 1'b0;
    n = 0;
    repeat (60) begin @(negedge clk); if (busy) n++; end
    chk(n == 60, "no_timeout_busy", $sformatf("got busy for %0d of 60 cycles, required 60", n));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last = GRANT_B;
`endif
    rf_mute = 1'b0;

    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "resp_drained", $sformatf("got %0d responses outstanding, required 0", exp_q.size()));
    chk(rf_q.size() == 0, "rf_drained", $sformatf("got %0d rf commands outstanding, required 0", rf_q.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decryption_regfile_arbiter.md
DECRYPTION_REGFILE_ARBITER -- requirements
Module: decryption_regfile_arbiter

Interface
REQ-001 Parameter addr_width, 8, width of the register address.
REQ-002 Parameter reg_width, 16, width of register data.
REQ-003 Parameter timeout_cycles, 15, number of WAIT cycles before forced error (used only with ARB_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 a_req / b_req  in  1  level request from requester A / B.
REQ-007 a_we / b_we  in  1  1 = write, 0 = read.
REQ-008 a_addr / b_addr  in  addr_width  target register address.
REQ-009 a_wdata / b_wdata  in  reg_width  write data.
REQ-010 a_rdata / b_rdata  out  reg_width  read result, valid while done is high.
REQ-011 a_done / b_done  out  1  one-cycle completion pulse.
REQ-012 a_error / b_error  out  1  error flag, valid with done only.
REQ-013 rf_addr  out  addr_width, rf_wdata  out  reg_width, rf_read  out  1, rf_write  out  1  shared regfile access bus.
REQ-014 rf_rdata  in  reg_width, rf_done  in  1, rf_error  in  1  regfile response.
REQ-015 busy  out  1  high in every state except IDLE; owner  out  1  0 = A, 1 = B, current or last grantee.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-017 IDLE: with any req high, select a grantee, latch its we/addr/wdata, go to ISSUE next cycle; otherwise stay.
REQ-018 Simultaneous a_req and b_req: grant the requester not granted last (round-robin); last-grant pointer resets to B, so A wins the first tie.
REQ-019 A single requesting side is granted regardless of the pointer; the pointer updates only on entry to RESP.
REQ-020 ISSUE: assert exactly one of rf_read/rf_write for exactly one cycle with latched rf_addr/rf_wdata, then go to WAIT.
REQ-021 rf_addr and rf_wdata SHALL hold the latched values from ISSUE through RESP.
REQ-022 WAIT: on rf_done high, capture rf_rdata (reads only; 0 for writes) and rf_error, then go to RESP.
REQ-023 RESP: pulse the grantee's done for one cycle with captured rdata/error; the other requester's done stays 0; return to IDLE.
REQ-024 Latency: req sampled at edge N -> rf strobe during cycle N+1 -> regfile done at N+2 -> grantee done during cycle N+3 (regfile responding in one cycle).
REQ-025 req is a level: one transaction per done pulse. A req still high in IDLE after RESP starts a new transaction, subject to round-robin.
REQ-026 Non-grantee requests stay pending without loss; command inputs SHALL be stable while req is high.
REQ-027 rdata/error outputs SHALL be 0 whenever the matching done is 0.

Reset
REQ-028 rst high at a clock edge: state IDLE, rf_read = rf_write = 0, rf_addr = rf_wdata = 0, all done/error/rdata = 0, busy = 0, owner = 1, pointer = B.
REQ-029 Reset mid-transaction aborts it; no done pulse is issued for the aborted transaction and rf_done arriving after reset is ignored.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN defined: a counter runs in WAIT. On reaching timeout_cycles without rf_done, go to RESP with error = 1 and rdata = 0. The counter clears on entry to WAIT.
REQ-031 ARB_TIMEOUT_EN undefined: no counter is present and WAIT persists until rf_done.

Structure
REQ-032 Shared package decryption_pkg: FSM state typedef, register address constants (SELECT 0x00, CAESAR 0x10, SCYTALE 0x12, ZIGZAG 0x14), default widths.
REQ-033 The two-way round-robin choice SHALL be one sub-module, decryption_rr_pick (inputs: two reqs and pointer; outputs: grant, valid).

Verification
REQ-034 A write 0x10 <- 0x0003 alone -> rf_write pulse 1 cycle, rf_addr 0x10, a_done at N+3, a_error 0.
REQ-035 A and B request simultaneously after reset (A read 0x12, B read 0x14) -> A served first (rdata 0xFFFF), then B (rdata 0x0002); no overlap of rf strobes.
REQ-036 B read 0x20 (unmapped) -> rf_error returned, b_done with b_error 1, b_rdata 0.
REQ-037 Both reqs held high for 4 transactions -> grants alternate A, B, A, B.
REQ-038 rst asserted during WAIT -> no done pulse, all outputs 0, busy 0 the next cycle; a following request completes normally.
REQ-039 With ARB_TIMEOUT_EN, rf_done tied 0 -> a_done with a_error 1 after 15 WAIT cycles; without the macro, busy stays high indefinitely.
